// File: rtl/lotr_pkg.sv
// Shared LOTR ring types: opcodes, memory region map and the F2C response entry.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'b00,
        WR     = 2'b01,
        RD_RSP = 2'b10
    } t_opcode;

    localparam int MSB_REGION = 31;
    localparam int LSB_REGION = 28;
    localparam int REGION_W   = MSB_REGION - LSB_REGION + 1;

    localparam logic [REGION_W-1:0] I_MEM_REGION = 4'h0;
    localparam logic [REGION_W-1:0] D_MEM_REGION = 4'h1;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [7:0]  tag;
    } t_f2c_rsp;

endpackage

// File: rtl/f2c_rsp_fifo.sv
// Read-response buffer: power-of-two depth, head presented straight from storage.
module f2c_rsp_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  t_f2c_rsp               push_data,
    input  logic                   pop,
    output logic                   valid,
    output t_f2c_rsp               head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    t_f2c_rsp               mem_q [DEPTH];
    t_f2c_rsp               mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pop_eff;
    logic                   full;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_eff = pop && valid;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers are PTR_W wide, so the increment wraps modulo DEPTH on its own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop_eff));

endmodule

// File: rtl/f2c_req_ctrl.sv
// Ring-to-memory request controller: forwards requests to i_mem/d_mem, buffers read responses.
module f2c_req_ctrl
    import lotr_pkg::*;
#(
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        RingReqValidQ502H,
    output logic        RingReqReadyQ502H,
    input  t_opcode     RingReqOpcodeQ502H,
    input  logic [31:0] RingReqAddressQ502H,
    input  logic [31:0] RingReqDataQ502H,
    input  logic [7:0]  RingReqTagQ502H,
    output logic        F2C_ReqValidQ503H,
    output t_opcode     F2C_ReqOpcodeQ503H,
    output logic [31:0] F2C_ReqAddressQ503H,
    output logic [31:0] F2C_ReqDataQ503H,
    input  logic        F2C_RspIMemValidQ504H,
    input  logic [31:0] F2C_I_MemRspDataQ504H,
    input  logic        F2C_RspDMemValidQ504H,
    input  logic [31:0] F2C_D_MemRspDataQ504H,
    output logic        RingRspValidQ505H,
    output t_opcode     RingRspOpcodeQ505H,
    output logic [31:0] RingRspAddressQ505H,
    output logic [31:0] RingRspDataQ505H,
    output logic [7:0]  RingRspTagQ505H,
    input  logic        RingRspReadyQ505H
);

    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(RSP_FIFO_DEPTH);

    logic                req_vld_q,  req_vld_d;
    t_opcode             req_op_q,   req_op_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic [31:0]         req_data_q, req_data_d;
    logic [7:0]          req_tag_q,  req_tag_d;

    logic                rd_q,       rd_d;
    logic                i_hit_q,    i_hit_d;
    logic                d_hit_q,    d_hit_d;
    logic [31:0]         addr504_q,  addr504_d;
    logic [7:0]          tag504_q,   tag504_d;

    logic                accept;
    logic                rd_503;
    logic [REGION_W-1:0] region_503;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      credits_used;
    t_f2c_rsp            rsp_push;
    t_f2c_rsp            rsp_head;

    // Credits reserve a buffer slot for every read still in the pipe, so a read is never refused at Q504.
    assign credits_used      = {1'b0, fifo_count} + (CNT_W+1)'(rd_503) + (CNT_W+1)'(rd_q);
    assign RingReqReadyQ502H = !RstQnnnH && (credits_used < CREDITS);
    assign accept            = RingReqValidQ502H && RingReqReadyQ502H;
    assign rd_503            = req_vld_q && (req_op_q == RD);
    assign region_503        = req_addr_q[MSB_REGION:LSB_REGION];

    always_comb begin
        req_vld_d  = accept;
        req_op_d   = req_op_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_tag_d  = req_tag_q;
        if (accept) begin
            req_op_d   = RingReqOpcodeQ502H;
            req_addr_d = RingReqAddressQ502H;
            req_data_d = RingReqDataQ502H;
            req_tag_d  = RingReqTagQ502H;
        end
    end

    always_comb begin
        rd_d      = rd_503;
        i_hit_d   = i_hit_q;
        d_hit_d   = d_hit_q;
        addr504_d = addr504_q;
        tag504_d  = tag504_q;
        if (rd_503) begin
            i_hit_d   = (region_503 == I_MEM_REGION);
            d_hit_d   = (region_503 == D_MEM_REGION);
            addr504_d = req_addr_q;
            tag504_d  = req_tag_q;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            req_vld_q  <= 1'b0;
            req_op_q   <= RD;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_tag_q  <= '0;
            rd_q       <= 1'b0;
            i_hit_q    <= 1'b0;
            d_hit_q    <= 1'b0;
            addr504_q  <= '0;
            tag504_q   <= '0;
        end else begin
            req_vld_q  <= req_vld_d;
            req_op_q   <= req_op_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_tag_q  <= req_tag_d;
            rd_q       <= rd_d;
            i_hit_q    <= i_hit_d;
            d_hit_q    <= d_hit_d;
            addr504_q  <= addr504_d;
            tag504_q   <= tag504_d;
        end
    end

    assign F2C_ReqValidQ503H   = req_vld_q;
    assign F2C_ReqOpcodeQ503H  = req_op_q;
    assign F2C_ReqAddressQ503H = req_addr_q;
    assign F2C_ReqDataQ503H    = req_data_q;

    // Memory wraps have fixed latency; unmapped reads complete in the same slot with zero data.
    always_comb begin
        rsp_push.opcode  = RD_RSP;
        rsp_push.address = addr504_q;
        rsp_push.tag     = tag504_q;
        if (i_hit_q) begin
            rsp_push.data = F2C_I_MemRspDataQ504H;
        end else if (d_hit_q) begin
            rsp_push.data = F2C_D_MemRspDataQ504H;
        end else begin
            rsp_push.data = '0;
        end
    end

    f2c_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (QClk),
        .rst       (RstQnnnH),
        .push      (rd_q),
        .push_data (rsp_push),
        .pop       (RingRspReadyQ505H),
        .valid     (RingRspValidQ505H),
        .head      (rsp_head),
        .count     (fifo_count)
    );

    assign RingRspOpcodeQ505H  = rsp_head.opcode;
    assign RingRspAddressQ505H = rsp_head.address;
    assign RingRspDataQ505H    = rsp_head.data;
    assign RingRspTagQ505H     = rsp_head.tag;

    a_no_stray_mem_rsp : assert property (@(posedge QClk) disable iff (RstQnnnH)
        (F2C_RspIMemValidQ504H || F2C_RspDMemValidQ504H) |-> rd_q);

endmodule
